// File: rtl/fetch_stage_pkg.sv
// Shared LC-3b datapath types for the fetch stage and its pipeline registers.
package fetch_stage_pkg;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_DRAIN = 2'd1,
    S_HOLD  = 2'd2
  } fetch_state_t;

  localparam lc3b_word PC_STEP = 16'd2;

endpackage

// File: rtl/fetch_stage_ifid_register.sv
// Pipeline register holding valid/ir/pc; flush clears only valid so a flushed entry never re-emerges.
module ifid_register
  import fetch_stage_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     i_load,
  input  logic     i_flush,
  input  lc3b_word i_ir,
  input  lc3b_word i_pc,
  output logic     o_valid,
  output lc3b_word o_ir,
  output lc3b_word o_pc
);

  logic     r_valid;
  lc3b_word r_ir;
  lc3b_word r_pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_ir    <= '0;
      r_pc    <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_ir    <= i_ir;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_ir    = r_ir;
  assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// LC-3b fetch stage: owns the PC, runs the imem read handshake, and feeds IF/ID
// through a one-word skid register when decode stalls.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         rst,
  output lc3b_word     imem_address,
  output logic         imem_read,
  input  lc3b_word     imem_rdata,
  input  logic         imem_resp,
  input  logic         stall_in,
  input  logic         redirect_valid,
  input  lc3b_word     redirect_pc,
  output logic         ifid_valid,
  output lc3b_word     ifid_ir,
  output lc3b_word     ifid_pc,
  output lc3b_opcode   ifid_opcode,
  output logic         ifid_a,
  output logic         ifid_d,
  output logic [2:0]   ifid_ext3,
  output logic [15:0]  fetch_count,
  output fetch_state_t dbg_state
);

  // Handshakes: a read is requested while imem_read=1 and completes on the cycle
  // imem_resp=1 (address held stable until then); an IF/ID entry is presented while
  // ifid_valid=1 and is taken by decode on any edge where stall_in=0.
  fetch_state_t r_state, w_state_next;
  lc3b_word     r_pc, r_skid_ir, r_skid_pc, r_tgt;
  logic [15:0]  r_fetch_count;

  logic     w_ifid_valid, w_accept, w_consume;
  logic     w_read, w_load, w_pc_we, w_skid_we, w_tgt_we;
  lc3b_word w_pc_inc, w_pc_next, w_load_ir, w_load_pc;

  assign w_accept  = !w_ifid_valid || !stall_in;
  assign w_consume = w_ifid_valid && !stall_in;
  assign w_pc_inc  = r_pc + PC_STEP;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (imem_resp) begin
          if (!redirect_valid && !w_accept) w_state_next = S_HOLD;
        end else if (redirect_valid) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: if (imem_resp) w_state_next = S_FETCH;
      S_HOLD:  if (redirect_valid || w_accept) w_state_next = S_FETCH;
      default: w_state_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_read    = 1'b0;
    w_load    = 1'b0;
    w_load_ir = r_skid_ir;
    w_load_pc = r_skid_pc;
    w_pc_we   = 1'b0;
    w_pc_next = r_pc;
    w_skid_we = 1'b0;
    w_tgt_we  = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_read = 1'b1;
        if (imem_resp) begin
          w_pc_we = 1'b1;
          if (redirect_valid) begin
            w_pc_next = redirect_pc;
          end else begin
            w_pc_next = w_pc_inc;
            if (w_accept) begin
              w_load    = 1'b1;
              w_load_ir = imem_rdata;
              w_load_pc = w_pc_inc;
            end else begin
              w_skid_we = 1'b1;
            end
          end
        end else if (redirect_valid) begin
          w_tgt_we = 1'b1;
        end
      end
      // The in-flight read cannot be abandoned, so its word is discarded on arrival.
      S_DRAIN: begin
        w_read = 1'b1;
        if (imem_resp) begin
          w_pc_we   = 1'b1;
          w_pc_next = redirect_valid ? redirect_pc : r_tgt;
        end else if (redirect_valid) begin
          w_tgt_we = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid) begin
          w_pc_we   = 1'b1;
          w_pc_next = redirect_pc;
        end else if (w_accept) begin
          w_load = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_skid_ir     <= '0;
      r_skid_pc     <= '0;
      r_tgt         <= '0;
      r_fetch_count <= '0;
    end else begin
      if (w_pc_we) r_pc <= w_pc_next;
      if (w_skid_we) begin
        r_skid_ir <= imem_rdata;
        r_skid_pc <= w_pc_inc;
      end
      if (w_tgt_we) r_tgt <= redirect_pc;
      if (w_load) r_fetch_count <= r_fetch_count + 16'd1;
    end
  end

  ifid_register u_ifid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_flush (redirect_valid || (w_consume && !w_load)),
    .i_ir    (w_load_ir),
    .i_pc    (w_load_pc),
    .o_valid (w_ifid_valid),
    .o_ir    (ifid_ir),
    .o_pc    (ifid_pc)
  );

  assign imem_read    = w_read && !rst;
  assign imem_address = r_pc;
  assign ifid_valid   = w_ifid_valid;
  assign ifid_opcode  = ifid_ir[15:12];
  assign ifid_a       = ifid_ir[5];
  assign ifid_d       = ifid_ir[4];
  assign ifid_ext3    = ifid_ir[2:0];
  assign fetch_count  = r_fetch_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle table, hand-written corner sequences, and a
// randomized run against a buffer-level model of the fetch stream.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic         clk;
  logic         rst;
  lc3b_word     imem_address;
  logic         imem_read;
  lc3b_word     imem_rdata;
  logic         imem_resp;
  logic         stall_in;
  logic         redirect_valid;
  lc3b_word     redirect_pc;
  logic         ifid_valid;
  lc3b_word     ifid_ir;
  lc3b_word     ifid_pc;
  lc3b_opcode   ifid_opcode;
  logic         ifid_a;
  logic         ifid_d;
  logic [2:0]   ifid_ext3;
  logic [15:0]  fetch_count;
  fetch_state_t dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  fetch_stage #(.RESET_PC(16'h0000)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_address   (imem_address),
    .imem_read      (imem_read),
    .imem_rdata     (imem_rdata),
    .imem_resp      (imem_resp),
    .stall_in       (stall_in),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_ir        (ifid_ir),
    .ifid_pc        (ifid_pc),
    .ifid_opcode    (ifid_opcode),
    .ifid_a         (ifid_a),
    .ifid_d         (ifid_d),
    .ifid_ext3      (ifid_ext3),
    .fetch_count    (fetch_count),
    .dbg_state      (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic lc3b_word mem_word(input lc3b_word addr);
    return {addr[7:0] ^ 8'hC3, addr[15:8] ^ 8'h5A};
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic s, input logic rv, input lc3b_word rp,
                       input logic resp, input lc3b_word rd);
    @(negedge clk);
    rst            = r;
    stall_in       = s;
    redirect_valid = rv;
    redirect_pc    = rp;
    imem_resp      = resp;
    imem_rdata     = rd;
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  // ---------------- cycle table ----------------
  typedef struct {
    logic        rst, stall, redir;
    logic [15:0] rpc;
    logic        resp;
    logic [15:0] rdata;
    logic        chk;
    logic        e_read;
    logic [15:0] e_addr;
    logic        e_valid;
    logic        chk_data;
    logic [15:0] e_ir, e_pc, e_count;
  } vec_t;

  vec_t vecs[14];

  // ---------------- random-phase model state ----------------
  logic [31:0] exp_q[$];
  lc3b_word    m_pc, m_tgt;
  logic        m_pend;
  logic [15:0] m_count;
  int          r_wait, lat;

  initial begin
    rst = 1'b1; stall_in = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_resp = 1'b0; imem_rdata = '0;

    //           rst stl rdr rpc      rsp rdata     chk rd addr      vld cd ir        pc        cnt
    vecs[0]  = '{1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b0,1'b0,16'h0000,1'b0,1'b0,16'h0000,16'h0000,16'd0};
    vecs[1]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1,16'h1042, 1'b1,1'b1,16'h0000,1'b0,1'b1,16'h0000,16'h0000,16'd0};
    vecs[2]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1,16'h2A05, 1'b1,1'b1,16'h0002,1'b1,1'b1,16'h1042,16'h0002,16'd1};
    vecs[3]  = '{1'b0,1'b0,1'b1,16'hFFFE,1'b1,16'h5555, 1'b1,1'b1,16'h0004,1'b1,1'b1,16'h2A05,16'h0004,16'd2};
    vecs[4]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1,16'hD029, 1'b1,1'b1,16'hFFFE,1'b0,1'b0,16'h0000,16'h0000,16'd2};
    vecs[5]  = '{1'b0,1'b1,1'b0,16'h0000,1'b1,16'h1234, 1'b1,1'b1,16'h0000,1'b1,1'b1,16'hD029,16'h0000,16'd3};
    vecs[6]  = '{1'b0,1'b1,1'b0,16'h0000,1'b0,16'h0000, 1'b1,1'b0,16'h0002,1'b1,1'b1,16'hD029,16'h0000,16'd3};
    vecs[7]  = '{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,1'b0,16'h0002,1'b1,1'b1,16'hD029,16'h0000,16'd3};
    vecs[8]  = '{1'b0,1'b0,1'b0,16'h0000,1'b1,16'h3141, 1'b1,1'b1,16'h0002,1'b1,1'b1,16'h1234,16'h0002,16'd4};
    vecs[9]  = '{1'b0,1'b0,1'b1,16'h0040,1'b1,16'h7777, 1'b1,1'b1,16'h0004,1'b1,1'b1,16'h3141,16'h0004,16'd5};
    vecs[10] = '{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,1'b1,16'h0040,1'b0,1'b0,16'h0000,16'h0000,16'd5};
    vecs[11] = '{1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,1'b0,16'h0040,1'b0,1'b0,16'h0000,16'h0000,16'd5};
    vecs[12] = '{1'b1,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,1'b0,16'h0000,1'b0,1'b1,16'h0000,16'h0000,16'd0};
    vecs[13] = '{1'b0,1'b0,1'b0,16'h0000,1'b0,16'h0000, 1'b1,1'b1,16'h0000,1'b0,1'b1,16'h0000,16'h0000,16'd0};

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].rst, vecs[i].stall, vecs[i].redir, vecs[i].rpc, vecs[i].resp, vecs[i].rdata);
      if (vecs[i].chk) begin
        chk($sformatf("tbl%0d_read", i), 32'(imem_read), 32'(vecs[i].e_read));
        chk($sformatf("tbl%0d_addr", i), 32'(imem_address), 32'(vecs[i].e_addr));
        chk($sformatf("tbl%0d_valid", i), 32'(ifid_valid), 32'(vecs[i].e_valid));
        chk($sformatf("tbl%0d_count", i), 32'(fetch_count), 32'(vecs[i].e_count));
        if (vecs[i].chk_data) begin
          chk($sformatf("tbl%0d_ir", i), 32'(ifid_ir), 32'(vecs[i].e_ir));
          chk($sformatf("tbl%0d_pc", i), 32'(ifid_pc), 32'(vecs[i].e_pc));
          chk($sformatf("tbl%0d_fields", i), {ifid_opcode, ifid_a, ifid_d, ifid_ext3},
              {vecs[i].e_ir[15:12], vecs[i].e_ir[5], vecs[i].e_ir[4], vecs[i].e_ir[2:0]});
        end
      end
    end

    // Slow imem (3 cycles) while decode stalls for 4 cycles: word parks in skid.
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("skid_pre_addr", 32'(imem_address), 32'h0002);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'h2222);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("skid_state", 32'(dbg_state), 32'(S_HOLD));
    chk("skid_read", 32'(imem_read), 32'd0);
    chk("skid_ifid", {ifid_ir, ifid_pc}, {16'h1111, 16'h0002});
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("skid_hold_ifid", {ifid_ir, ifid_pc}, {16'h1111, 16'h0002});
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("skid_out_ifid", {ifid_ir, ifid_pc}, {16'h2222, 16'h0004});
    chk("skid_out_valid", 32'(ifid_valid), 32'd1);
    chk("skid_out_count", 32'(fetch_count), 32'd2);
    chk("skid_out_addr", {15'd0, imem_read, imem_address}, {15'd0, 1'b1, 16'h0004});

    // Redirect two cycles into a 3-cycle read: address held, word discarded.
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h1111);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b1, 16'h3000, 1'b0, 16'h0);
    drive(1'b0, 1'b1, 1'b0, 16'h0, 1'b1, 16'hBEEF);
    chk("drain_addr", {15'd0, imem_read, imem_address}, {15'd0, 1'b1, 16'h0002});
    chk("drain_valid", 32'(ifid_valid), 32'd0);
    chk("drain_state", 32'(dbg_state), 32'(S_DRAIN));
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("drain_next_addr", {15'd0, imem_read, imem_address}, {15'd0, 1'b1, 16'h3000});
    chk("drain_count", 32'(fetch_count), 32'd1);
    chk("drain_valid2", 32'(ifid_valid), 32'd0);
    // Latest redirect wins during drain; a redirect on the resp cycle wins over tgt.
    drive(1'b0, 1'b0, 1'b1, 16'h4000, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 16'h5000, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 16'h9999);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("drain_latest", 32'(imem_address), 32'h5000);
    drive(1'b0, 1'b0, 1'b1, 16'h6000, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 1'b1, 16'h7000, 1'b1, 16'h9999);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 1'b0, 16'h0);
    chk("drain_resp_redir", 32'(imem_address), 32'h7000);
    chk("drain_resp_valid", 32'(ifid_valid), 32'd0);

    // Randomized run against the buffer-level model.
    r_wait = 0;
    lat = 1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst            = (c < 2) || ($urandom_range(0, 199) == 0);
      stall_in       = ($urandom_range(0, 99) < 40);
      redirect_valid = ($urandom_range(0, 99) < 8);
      redirect_pc    = ($urandom_range(0, 7) == 0) ? 16'hFFFE : 16'($urandom_range(0, 32767) * 2);
      #1;
      imem_resp  = imem_read && (r_wait >= lat - 1);
      imem_rdata = imem_resp ? mem_word(imem_address) : 16'h0;
      #1;
      if (rst) begin
        chk("rnd_rst_read", 32'(imem_read), 32'd0);
        exp_q.delete();
        m_pc = 16'h0000; m_pend = 1'b0; m_count = 16'd0; m_tgt = 16'h0;
      end else begin
        int  pre;
        logic rd, cons;
        pre  = exp_q.size();
        rd   = (pre < 2);
        cons = (pre > 0) && !stall_in;
        chk("rnd_read", 32'(imem_read), 32'(rd));
        if (rd) chk("rnd_addr", 32'(imem_address), 32'(m_pc));
        chk("rnd_valid", 32'(ifid_valid), 32'(pre > 0));
        if (pre > 0) chk("rnd_entry", {ifid_ir, ifid_pc}, exp_q[0]);
        chk("rnd_count", 32'(fetch_count), 32'(m_count));
        if (redirect_valid) exp_q.delete();
        else if (cons) begin
          void'(exp_q.pop_front());
          if (pre == 2) m_count++;
        end
        if (rd) begin
          if (imem_resp) begin
            if (redirect_valid) begin m_pc = redirect_pc; m_pend = 1'b0; end
            else if (m_pend) begin m_pc = m_tgt; m_pend = 1'b0; end
            else begin
              exp_q.push_back({mem_word(m_pc), m_pc + 16'd2});
              if (exp_q.size() == 1) m_count++;
              m_pc = m_pc + 16'd2;
            end
          end else if (redirect_valid) begin
            m_pend = 1'b1;
            m_tgt  = redirect_pc;
          end
        end else if (redirect_valid) begin
          m_pc = redirect_pc;
        end
      end
      if (!imem_read || imem_resp) begin
        r_wait = 0;
        if (imem_resp) lat = $urandom_range(1, 3);
      end else begin
        r_wait++;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
